// File: rtl/ltf_peak_detector.sv
// ltf_peak_detector: pipelined max tree over LTF correlator phases followed by threshold/window peak search.
// Optional search timeout enabled by defining PEAK_DET_TIMEOUT_EN.
module ltf_peak_detector #(
  parameter int PHASES       = 64,
  parameter int MAG_W        = 32,
  parameter int WIN_BLOCKS   = 4,
  parameter int CNT_W        = 16,
  parameter int TIMEOUT_BLKS = 4096
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [MAG_W*PHASES-1:0]            corr_i,
  input  logic                               corr_valid_i,
  input  logic [MAG_W-1:0]                   threshold_i,
  input  logic                               arm_i,
  output logic                               busy_o,
  output logic                               lock_o,
  output logic [MAG_W-1:0]                   peak_mag_o,
  output logic [CNT_W+$clog2(PHASES)-1:0]    peak_sample_o,
  output logic                               timeout_o
);
  localparam int PW = $clog2(PHASES);
  localparam int SW = CNT_W + PW;
  localparam int WW = $clog2(WIN_BLOCKS + 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(WIN_BLOCKS - 1);
  typedef enum logic [1:0] {IDLE, SEARCH, WINDOW, LOCKED} state_t;
  // Heap-ordered tree: node i has children 2i/2i+1; indices >= PHASES are the raw input phases.
  logic [MAG_W-1:0] nm [1:PHASES-1];
  logic [PW-1:0]    np [1:PHASES-1];
  logic             nv [1:PHASES-1];
  for (genvar i = 1; i < PHASES; i++) begin : g_node
    logic [MAG_W-1:0] lm, rm;
    logic [PW-1:0]    lp, rp;
    logic             lv;
    if (2 * i >= PHASES) begin : g_leaf
      assign lm = corr_i[(2*i-PHASES)*MAG_W +: MAG_W];
      assign rm = corr_i[(2*i+1-PHASES)*MAG_W +: MAG_W];
      assign lp = PW'(2*i - PHASES);
      assign rp = PW'(2*i + 1 - PHASES);
      assign lv = corr_valid_i;
    end else begin : g_int
      assign lm = nm[2*i];
      assign rm = nm[2*i+1];
      assign lp = np[2*i];
      assign rp = np[2*i+1];
      assign lv = nv[2*i];
    end
    // Left subtree always holds the lower phases, so >= gives ties to the lower index.
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
        nm[i] <= '0;
        np[i] <= '0;
        nv[i] <= 1'b0;
      end else begin
        nm[i] <= (lm >= rm) ? lm : rm;
        np[i] <= (lm >= rm) ? lp : rp;
        nv[i] <= lv;
      end
  end
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  blk_q, blk_d;
  logic [MAG_W-1:0]  cmag_q, cmag_d;
  logic [SW-1:0]     csmp_q, csmp_d;
  logic [WW-1:0]     win_q, win_d;
  logic              tout_d;
  logic [SW-1:0]     rsmp;
  assign rsmp = {blk_q, np[1]};
`ifdef PEAK_DET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_BLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_BLKS - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tout_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      tmo_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      tout_q <= tout_d;
    end
  assign timeout_o = tout_q;
`else
  assign timeout_o = 1'b0;
`endif
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      blk_q   <= '0;
      cmag_q  <= '0;
      csmp_q  <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      cmag_q  <= cmag_d;
      csmp_q  <= csmp_d;
      win_q   <= win_d;
    end
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    cmag_d  = cmag_q;
    csmp_d  = csmp_q;
    win_d   = win_q;
    tout_d  = 1'b0;
`ifdef PEAK_DET_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    if (arm_i) begin
      state_d = SEARCH;
      blk_d   = '0;
      cmag_d  = '0;
      csmp_d  = '0;
      win_d   = '0;
`ifdef PEAK_DET_TIMEOUT_EN
      tmo_d   = '0;
`endif
    end else if (nv[1] && (state_q == SEARCH || state_q == WINDOW)) begin
      blk_d = (&blk_q) ? blk_q : blk_q + 1'b1;
      if (state_q == SEARCH) begin
        if (nm[1] > threshold_i) begin
          state_d = WINDOW;
          cmag_d  = nm[1];
          csmp_d  = rsmp;
          win_d   = '0;
        end
`ifdef PEAK_DET_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          tout_d  = 1'b1;
        end else
          tmo_d = tmo_q + 1'b1;
`endif
      end else begin
        cmag_d  = (nm[1] > cmag_q) ? nm[1] : cmag_q;
        csmp_d  = (nm[1] > cmag_q) ? rsmp : csmp_q;
        win_d   = win_q + 1'b1;
        state_d = (win_q == WIN_LAST) ? LOCKED : WINDOW;
      end
    end
  end
  assign busy_o        = (state_q == SEARCH) || (state_q == WINDOW);
  assign lock_o        = (state_q == LOCKED);
  assign peak_mag_o    = lock_o ? cmag_q : '0;
  assign peak_sample_o = lock_o ? csmp_q : '0;
endmodule

// File: tb/tb_ltf_peak_detector.sv
// tb_ltf_peak_detector: directed scoreboard bench; expected peaks are queued by stimulus and checked when lock_o rises.
module tb_ltf_peak_detector;
  localparam int PHASES = 64;
  localparam int MAG_W  = 32;
  localparam int CNT_W  = 16;
  localparam int TMO    = 12;
  localparam int SW     = CNT_W + $clog2(PHASES);
  typedef struct { logic [MAG_W-1:0] mag; logic [SW-1:0] smp; } exp_t;
  logic                    clk_i = 1'b0;
  logic                    rst_ni = 1'b0;
  logic [MAG_W*PHASES-1:0] corr_i = '0;
  logic                    corr_valid_i = 1'b0;
  logic [MAG_W-1:0]        threshold_i = 32'd1000;
  logic                    arm_i = 1'b0;
  logic                    busy_o, lock_o, timeout_o;
  logic [MAG_W-1:0]        peak_mag_o;
  logic [SW-1:0]           peak_sample_o;
  exp_t                    sb[$];
  int                      checks = 0;
  int                      passes = 0;
  int                      tmo_pulses = 0;
  logic                    lock_q = 1'b0;
  ltf_peak_detector #(.PHASES(PHASES), .MAG_W(MAG_W), .WIN_BLOCKS(4), .CNT_W(CNT_W), .TIMEOUT_BLKS(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .corr_i(corr_i), .corr_valid_i(corr_valid_i),
    .threshold_i(threshold_i), .arm_i(arm_i), .busy_o(busy_o), .lock_o(lock_o),
    .peak_mag_o(peak_mag_o), .peak_sample_o(peak_sample_o), .timeout_o(timeout_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  always @(negedge clk_i) begin
    if (lock_o && !lock_q) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_lock: got lock with peak_mag %0d, expected none", peak_mag_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("peak_mag", 64'(peak_mag_o), 64'(e.mag));
        chk("peak_sample", 64'(peak_sample_o), 64'(e.smp));
      end
    end
    lock_q = lock_o;
    if (timeout_o) tmo_pulses++;
  end
  task automatic blk(input int pa, input int ma, input int pb, input int mb);
    corr_i = '0;
    corr_i[pa*MAG_W +: MAG_W] = MAG_W'(ma);
    if (pb >= 0) corr_i[pb*MAG_W +: MAG_W] = MAG_W'(mb);
    corr_valid_i = 1'b1;
    @(posedge clk_i); #1;
    corr_valid_i = 1'b0;
  endtask
  task automatic zeros(input int n);
    for (int k = 0; k < n; k++) blk(0, 0, -1, 0);
  endtask
  task automatic idle(input int n);
    corr_valid_i = 1'b0;
    repeat (n) begin @(posedge clk_i); #1; end
  endtask
  task automatic arm();
    idle(10);
    arm_i = 1'b1;
    @(posedge clk_i); #1;
    arm_i = 1'b0;
  endtask
  task automatic wait_lock(input string name);
    int n;
    n = 0;
    while (!lock_o && n < 40) begin @(negedge clk_i); n++; end
    if (!lock_o) begin
      checks++;
      $display("FAIL %s: got no lock within 40 cycles, expected lock", name);
    end
    @(negedge clk_i); #1;
  endtask
  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_lock", 64'(lock_o), 0);
    chk("rst_peak_mag", 64'(peak_mag_o), 0);
    chk("rst_peak_sample", 64'(peak_sample_o), 0);
    chk("rst_timeout", 64'(timeout_o), 0);
    rst_ni = 1'b1;
    idle(2);
    arm();
    tmo_pulses = 0;
`ifdef PEAK_DET_TIMEOUT_EN
    zeros(20);
    idle(10);
    chk("timeout_pulses", 64'(tmo_pulses), 1);
    chk("timeout_idle_busy", 64'(busy_o), 0);
`else
    zeros(50);
    chk("zeros_busy_mid", 64'(busy_o), 1);
    zeros(50);
    idle(10);
    chk("zeros_busy", 64'(busy_o), 1);
    chk("zeros_lock", 64'(lock_o), 0);
    chk("zeros_timeout", 64'(tmo_pulses), 0);
`endif
    arm();
    zeros(5);
    blk(10, 2000, -1, 0);
    zeros(1);
    blk(3, 5000, -1, 0);
    zeros(1);
    idle(10);
    chk("win_lock_early", 64'(lock_o), 0);
    chk("win_busy", 64'(busy_o), 1);
    sb.push_back('{mag: 32'd5000, smp: 22'd451});
    zeros(1);
    wait_lock("peak_451");
    chk("locked_busy", 64'(busy_o), 0);
    arm();
    chk("rearm_lock", 64'(lock_o), 0);
    chk("rearm_peak_mag", 64'(peak_mag_o), 0);
    zeros(2);
    blk(20, 1500, 40, 1500);
    sb.push_back('{mag: 32'd1500, smp: 22'd148});
    zeros(4);
    wait_lock("tie_148");
    arm();
    zeros(3);
    blk(17, 1000, -1, 0);
    zeros(5);
    blk(0, 1001, -1, 0);
    sb.push_back('{mag: 32'd1001, smp: 22'd576});
    zeros(4);
    wait_lock("strict_576");
    arm();
    zeros(2);
    blk(5, 3000, -1, 0);
    idle(2);
    blk(6, 4000, -1, 0);
    idle(10);
    arm_i = 1'b1;
    @(posedge clk_i); #1;
    arm_i = 1'b0;
    zeros(1);
    blk(7, 1200, -1, 0);
    idle(1);
    zeros(1);
    idle(2);
    blk(1, 1100, -1, 0);
    zeros(1);
    idle(10);
    chk("rearm_win_lock_early", 64'(lock_o), 0);
    sb.push_back('{mag: 32'd1200, smp: 22'd71});
    zeros(1);
    wait_lock("rearm_71");
    arm();
    blk(0, 2000, -1, 0);
    zeros(1);
    idle(10);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy_o), 0);
    chk("async_rst_lock", 64'(lock_o), 0);
    chk("async_rst_peak_mag", 64'(peak_mag_o), 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    zeros(6);
    idle(10);
    chk("post_rst_lock", 64'(lock_o), 0);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
